// File: rtl/karatsuba_pkg.sv
// rtl/karatsuba_pkg.sv - shared state encoding and select constants for the Karatsuba sequencer and datapath
package karatsuba_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLR,
    ST_LO,
    ST_HI,
    ST_MID,
    ST_DONE
  } state_t;

  // Multiplier input / Z write-source selects (sel_x, sel_y, sel_z share one code)
  localparam logic [1:0] SEL_CLR    = 2'b11;
  localparam logic [1:0] SEL_LO     = 2'b01;
  localparam logic [1:0] SEL_HI     = 2'b10;
  localparam logic [1:0] SEL_MID    = 2'b00;

  // T register source select
  localparam logic [1:0] SEL_T_HOLD = 2'b00;
  localparam logic [1:0] SEL_T_MID  = 2'b01;

endpackage

// File: rtl/karatsuba_seq_ctrl_phase_timer.sv
// rtl/karatsuba_seq_ctrl_phase_timer.sv - per-phase multiplier-latency wait counter
module phase_timer #(
  parameter int MULT_LAT = 0,
  parameter int CNT_W    = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  output logic o_tc
);

  logic [CNT_W-1:0] r_cnt;

  // Free-running count inside a phase; the FSM clears it on every phase change
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_tc = (r_cnt == CNT_W'(MULT_LAT));

endmodule

// File: rtl/karatsuba_seq_ctrl.sv
// rtl/karatsuba_seq_ctrl.sv - handshaked Karatsuba phase sequencer; KARATSUBA_SEQ_B2B_EN enables DONE->CLR back-to-back
module karatsuba_seq_ctrl
  import karatsuba_pkg::*;
#(
  parameter int MULT_LAT = 0,
  parameter int CNT_W    = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,          // asynchronous, active-low
  input  logic       i_start_valid,
  output logic       o_start_ready,
  input  logic       i_abort,
  output logic       o_res_valid,
  input  logic       i_res_ready,
  output logic       o_load_ab,
  output logic [1:0] o_sel_x,
  output logic [1:0] o_sel_y,
  output logic [1:0] o_sel_z,
  output logic [1:0] o_sel_T,
  output logic       o_en_z,
  output logic       o_en_T,
  output logic       o_busy
);

  state_t r_state;
  state_t w_state_nxt;
  logic   w_tc;
  logic   w_cnt_phase;
  logic   w_tmr_clr;

  // Counter only runs inside the multiplier phases and restarts on any state change
  assign w_cnt_phase = (r_state == ST_LO) || (r_state == ST_HI) || (r_state == ST_MID);
  assign w_tmr_clr   = !w_cnt_phase || (w_state_nxt != r_state);

  phase_timer #(
    .MULT_LAT (MULT_LAT),
    .CNT_W    (CNT_W)
  ) u_phase_timer (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_clr (w_tmr_clr),
    .o_tc  (w_tc)
  );

  // State register
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and output decode; abort wins over every other request
  always_comb begin
    w_state_nxt   = r_state;
    o_start_ready = 1'b0;
    o_load_ab     = 1'b0;
    o_res_valid   = 1'b0;
    o_sel_x       = SEL_CLR;
    o_sel_T       = SEL_T_HOLD;
    o_en_z        = 1'b0;
    o_en_T        = 1'b0;
    o_busy        = (r_state != ST_IDLE);
    case (r_state)
      ST_IDLE: begin
        o_start_ready = 1'b1;
        o_load_ab     = i_start_valid;
        if (i_start_valid) w_state_nxt = ST_CLR;
      end
      ST_CLR: begin
        if (i_abort) begin
          w_state_nxt = ST_IDLE;
        end else begin
          o_en_z      = 1'b1;
          w_state_nxt = ST_LO;
        end
      end
      ST_LO: begin
        o_sel_x = SEL_LO;
        if (i_abort) begin
          w_state_nxt = ST_IDLE;
        end else if (w_tc) begin
          o_en_z      = 1'b1;
          w_state_nxt = ST_HI;
        end
      end
      ST_HI: begin
        o_sel_x = SEL_HI;
        if (i_abort) begin
          w_state_nxt = ST_IDLE;
        end else if (w_tc) begin
          o_en_z      = 1'b1;
          w_state_nxt = ST_MID;
        end
      end
      ST_MID: begin
        o_sel_x = SEL_MID;
        o_sel_T = SEL_T_MID;
        if (i_abort) begin
          w_state_nxt = ST_IDLE;
        end else if (w_tc) begin
          o_en_z      = 1'b1;
          o_en_T      = 1'b1;
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        o_res_valid = 1'b1;
`ifdef KARATSUBA_SEQ_B2B_EN
        o_start_ready = i_res_ready & ~i_abort;
`endif
        if (i_abort) begin
          w_state_nxt = ST_IDLE;
        end else if (i_res_ready) begin
`ifdef KARATSUBA_SEQ_B2B_EN
          if (i_start_valid) begin
            o_load_ab   = 1'b1;
            w_state_nxt = ST_CLR;
          end else begin
            w_state_nxt = ST_IDLE;
          end
`else
          w_state_nxt = ST_IDLE;
`endif
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign o_sel_y = o_sel_x;
  assign o_sel_z = o_sel_x;

endmodule
